// File: rtl/div_iter_param.sv
`default_nettype none
// ============================================================================
// div_iter_param : iterative restoring divider, 1 or 2 quotient bits/cycle.
// Optional macro DIV_ZERO_CHECK_EN short-circuits a zero divisor.  Rev 1.0
// ============================================================================
module div_iter_param #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 Rst_n,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_zero_o
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        END  = 2'd2
    } state_t;

    state_t state, next_state;

    // quo starts as |dividend|; quotient bits shift in from the bottom
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dsr;
    logic [WIDTH-1:0]   rem;
    logic [CW-1:0]      cnt;
    logic               neg1, neg2;
    logic               zero_pend;

    logic               accept;
    logic               zero_hit;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH-1:0]   step_quo, step_rem;
    logic [WIDTH:0]     trial;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   q_fix, r_fix, raw_a;

    assign accept = (state == IDLE) && start_i && !annul_i;
    assign abs1   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs2   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_ZERO_CHECK_EN
    assign zero_hit = (opdata2_i == '0);
`else
    assign zero_hit = 1'b0;
`endif

    // Extra top bit in diff keeps the borrow visible even when trial >= 2**WIDTH
    always_comb begin
        step_quo = quo;
        step_rem = rem;
        trial    = '0;
        diff     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial    = {step_rem, step_quo[WIDTH-1]};
            diff     = {1'b0, trial} - {2'b00, dsr};
            step_quo = {step_quo[WIDTH-2:0], ~diff[WIDTH+1]};
            if (!diff[WIDTH+1]) begin
                step_rem = diff[WIDTH-1:0];
            end else begin
                step_rem = trial[WIDTH-1:0];
            end
        end
    end

    assign q_fix = (neg1 ^ neg2) ? -quo : quo;
    assign r_fix = neg1 ? -rem : rem;
    assign raw_a = neg1 ? -quo : quo;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = ON;
            ON: begin
                if (annul_i) begin
                    next_state = IDLE;
                end else if (zero_pend || (cnt == LAST_CNT)) begin
                    next_state = END;
                end
            end
            END: if (annul_i || !start_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            quo       <= '0;
            dsr       <= '0;
            rem       <= '0;
            cnt       <= '0;
            neg1      <= 1'b0;
            neg2      <= 1'b0;
            zero_pend <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state  <= next_state;
            busy_o <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (accept) begin
                        quo       <= abs1;
                        dsr       <= abs2;
                        rem       <= '0;
                        cnt       <= '0;
                        neg1      <= signed_div_i & opdata1_i[WIDTH-1];
                        neg2      <= signed_div_i & opdata2_i[WIDTH-1];
                        zero_pend <= zero_hit;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (zero_pend) begin
                        // quo is still |dividend| here, raw_a restores its sign
                        result_o <= {raw_a, {WIDTH{1'b1}}};
                        ready_o  <= 1'b1;
                    end else if (cnt == LAST_CNT) begin
                        result_o <= {r_fix, q_fix};
                        ready_o  <= 1'b1;
                    end else begin
                        quo <= step_quo;
                        rem <= step_rem;
                        cnt <= cnt + 1'b1;
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_zero_o <= 1'b0;
        end else if ((state == ON) && !annul_i && zero_pend) begin
            div_zero_o <= 1'b1;
        end else if ((state == END) && (annul_i || !start_i)) begin
            div_zero_o <= 1'b0;
        end
    end
`else
    assign div_zero_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_iter_param.sv
`default_nettype none
// ============================================================================
// tb_div_iter_param : randomized self-checking bench for div_iter_param
// (32-bit radix-2 and 16-bit two-bits-per-cycle instances).  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_div_iter_param;
`ifdef DIV_ZERO_CHECK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        sg = 1'b0, start = 1'b0, annul = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [63:0] res;
    logic        rdy, busy, dz;

    logic        sg2 = 1'b0, start2 = 1'b0, annul2 = 1'b0;
    logic [15:0] a2 = '0, b2 = '0;
    logic [31:0] res2;
    logic        rdy2, busy2, dz2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_iter_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .Rst_n(rst_n), .signed_div_i(sg), .opdata1_i(a), .opdata2_i(b),
        .start_i(start), .annul_i(annul), .result_o(res), .ready_o(rdy),
        .busy_o(busy), .div_zero_o(dz)
    );

    div_iter_param #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut2 (
        .clk(clk), .Rst_n(rst_n), .signed_div_i(sg2), .opdata1_i(a2), .opdata2_i(b2),
        .start_i(start2), .annul_i(annul2), .result_o(res2), .ready_o(rdy2),
        .busy_o(busy2), .div_zero_o(dz2)
    );

    // Reference: {remainder, quotient} from plain integer arithmetic
    function automatic logic [63:0] model(int w, bit s, logic [63:0] x, logic [63:0] y);
        logic [63:0] mask, qu, ru;
        longint sx, sy, q, r;
        mask = (64'd1 << w) - 64'd1;
        sx = longint'(x);
        sy = longint'(y);
        if (s && x[w-1]) sx = sx - (longint'(1) << w);
        if (s && y[w-1]) sy = sy - (longint'(1) << w);
        if (y == 64'd0) begin
            if (ZCHK) begin
                q = longint'(mask);
                r = longint'(x);
            end else begin
                q = (sx < 0) ? longint'(1) : longint'(mask);
                r = sx;
            end
        end else begin
            q = sx / sy;
            r = sx % sy;
        end
        qu = q;
        ru = r;
        return ((ru & mask) << w) | (qu & mask);
    endfunction

    task automatic do_divide(input bit s, input logic [31:0] x, input logic [31:0] y,
                             input bit wiggle, input string tag);
        logic [63:0] exp;
        int          edges, exp_lat;
        bit          exp_dz;
        exp     = model(32, s, {32'd0, x}, {32'd0, y});
        exp_dz  = ZCHK && (y == 32'd0);
        exp_lat = exp_dz ? 1 : 33;
        @(negedge clk);
        sg = s; a = x; b = y; start = 1'b1; annul = 1'b0;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
            if (!rdy) begin
                a  = $urandom;
                b  = $urandom;
                sg = 1'($urandom);
                if (wiggle) start = 1'($urandom);
            end
        end while (!rdy && edges < 100);
        start = 1'b1;
        checks++;
        if (edges - 1 != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, want %0d", tag, edges - 1, exp_lat);
        end
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL %s result: got %h want %h", tag, res, exp);
        end
        checks++;
        if (dz !== exp_dz || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s flags: dz=%b busy=%b want dz=%b busy=1", tag, dz, busy, exp_dz);
        end
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || res !== exp) begin
            errors++;
            $display("FAIL %s hold: rdy=%b res=%h want rdy=1 res=%h", tag, rdy, res, exp);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy, busy, dz} !== 3'b000 || res !== 64'd0) begin
            errors++;
            $display("FAIL %s release: rdy=%b busy=%b dz=%b res=%h want all 0", tag, rdy, busy, dz, res);
        end
    endtask

    task automatic do_divide2(input bit s, input logic [15:0] x, input logic [15:0] y, input string tag);
        logic [63:0] full;
        logic [31:0] exp;
        int          edges, exp_lat;
        full    = model(16, s, {48'd0, x}, {48'd0, y});
        exp     = full[31:0];
        exp_lat = (ZCHK && y == 16'd0) ? 1 : 9;
        @(negedge clk);
        sg2 = s; a2 = x; b2 = y; start2 = 1'b1; annul2 = 1'b0;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
            if (!rdy2) begin
                a2 = 16'($urandom);
                b2 = 16'($urandom);
            end
        end while (!rdy2 && edges < 40);
        checks++;
        if (edges - 1 != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, want %0d", tag, edges - 1, exp_lat);
        end
        checks++;
        if (res2 !== exp) begin
            errors++;
            $display("FAIL %s result: got %h want %h", tag, res2, exp);
        end
        start2 = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy2, busy2} !== 2'b00 || res2 !== 32'd0) begin
            errors++;
            $display("FAIL %s release: rdy=%b busy=%b res=%h want 0", tag, rdy2, busy2, res2);
        end
    endtask

    task automatic test_reset;
        start = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy, busy, dz} !== 3'b000 || res !== 64'd0) begin
            errors++;
            $display("FAIL reset32: rdy=%b busy=%b dz=%b res=%h want all 0", rdy, busy, dz, res);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy2, busy2, dz2} !== 3'b000 || res2 !== 32'd0) begin
            errors++;
            $display("FAIL reset16: rdy=%b busy=%b dz=%b res=%h want all 0", rdy2, busy2, dz2, res2);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        do_divide(1'b0, 32'd100, 32'd7, 1'b0, "u100div7");
        do_divide(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "s-7div2");
        do_divide(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "s_overflow");
        do_divide(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, "uFFFFdiv16");
        do_divide(1'b0, 32'd5, 32'd0, 1'b0, "u5div0");
        do_divide(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0, "s-5div0");
    endtask

    task automatic test_random;
        logic [31:0] x, y;
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            case ($urandom_range(0, 4))
                0:       y = 32'($urandom_range(1, 15));
                1:       y = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                2:       y = 32'd0;
                default: y = $urandom;
            endcase
            do_divide(1'($urandom), x, y, 1'(i % 2), "random");
        end
    endtask

    task automatic test_annul;
        bit saw_rdy;
        @(negedge clk);
        sg = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1; annul = 1'b0;
        @(negedge clk);
        repeat (9) begin
            checks++;
            if (rdy !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL annul_pre: rdy=%b busy=%b want rdy=0 busy=1", rdy, busy);
            end
            @(negedge clk);
        end
        annul = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy, busy} !== 2'b00 || res !== 64'd0) begin
            errors++;
            $display("FAIL annul_abort: rdy=%b busy=%b res=%h want 0", rdy, busy, res);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL annul_blocks_start: busy=%b want 0", busy);
        end
        annul = 1'b0;
        start = 1'b0;
        saw_rdy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rdy) saw_rdy = 1'b1;
        end
        checks++;
        if (saw_rdy !== 1'b0) begin
            errors++;
            $display("FAIL annul_no_result: ready seen=%b want 0", saw_rdy);
        end
        do_divide(1'b0, 32'd1000, 32'd3, 1'b1, "after_annul");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        sg = 1'b1; a = 32'hDEAD_BEEF; b = 32'd17; start = 1'b1; annul = 1'b0;
        sg2 = 1'b0; a2 = 16'h1234; b2 = 16'd5; start2 = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy: busy=%b busy2=%b want 1", busy, busy2);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy, busy, dz, rdy2, busy2, dz2} !== 6'd0 || res !== 64'd0 || res2 !== 32'd0) begin
            errors++;
            $display("FAIL midrst_async: busy=%b busy2=%b rdy=%b rdy2=%b want all 0", busy, busy2, rdy, rdy2);
        end
        start = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bpc2;
        do_divide2(1'b0, 16'hFFFF, 16'h0003, "w16_FFFFdiv3");
        do_divide2(1'b1, 16'h8000, 16'hFFFF, "w16_overflow");
        do_divide2(1'b0, 16'h0009, 16'h0000, "w16_div0");
        for (int i = 0; i < 8; i++) begin
            do_divide2(1'($urandom), 16'($urandom), 16'($urandom_range(1, 300)), "w16_random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_reset_mid();
        test_bpc2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
